// File: rtl/mmult_opt_mdc_tile_sequencer_if.sv
// Streamer/engine-side handshake bundle of the tile sequencer: launch pulses,
// per-tile addresses and length out; ready flags and done pulses back.
interface mmult_opt_mdc_tile_sequencer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) ();
  logic              in1_ready;
  logic              in2_ready;
  logic              out_ready;
  logic              in1_done;
  logic              in2_done;
  logic              out_done;
  logic              in1_req;
  logic              in2_req;
  logic              out_req;
  logic              engine_start;
  logic [ADDR_W-1:0] in1_addr;
  logic [ADDR_W-1:0] in2_addr;
  logic [ADDR_W-1:0] out_addr;
  logic [LEN_W-1:0]  len;

  modport master (
    input  in1_ready, in2_ready, out_ready, in1_done, in2_done, out_done,
    output in1_req, in2_req, out_req, engine_start,
    output in1_addr, in2_addr, out_addr, len
  );

  modport slave (
    output in1_ready, in2_ready, out_ready, in1_done, in2_done, out_done,
    input  in1_req, in2_req, out_req, engine_start,
    input  in1_addr, in2_addr, out_addr, len
  );
endinterface

// File: rtl/mmult_opt_mdc_tile_sequencer.sv
// Splits one offloaded matmul job into n_tiles stream launches, advancing each
// stream base by its stride per tile, and pulses done_o once at job end.
//
// state | meaning
// IDLE  | waiting for start_i, config sampled here
// ISSUE | launch cycle of a tile; holds while any streamer is not ready
// WAIT  | collecting the three stream done pulses (sticky)
// NEXT  | finish the job or advance addresses to the next tile
// DONE  | one-cycle job-complete pulse
module mmult_opt_mdc_tile_sequencer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned TILE_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] in1_base_i,
  input  logic [ADDR_W-1:0] in2_base_i,
  input  logic [ADDR_W-1:0] out_base_i,
  input  logic [ADDR_W-1:0] in1_stride_i,
  input  logic [ADDR_W-1:0] in2_stride_i,
  input  logic [ADDR_W-1:0] out_stride_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [TILE_W-1:0] n_tiles_i,
  mmult_opt_mdc_tile_sequencer_if.master strm,
  output logic [TILE_W-1:0] tile_idx_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] in1_addr_q, in2_addr_q, out_addr_q;
  logic [ADDR_W-1:0] in1_stride_q, in2_stride_q, out_stride_q;
  logic [LEN_W-1:0]  len_q;
  logic [TILE_W-1:0] n_tiles_q, tile_idx_q;
  logic              req_q, empty_q;
  logic [2:0]        done_seen_q, done_seen_d;
  logic              all_ready, last_tile;

  assign all_ready   = strm.in1_ready & strm.in2_ready & strm.out_ready;
  assign done_seen_d = done_seen_q | {strm.out_done, strm.in2_done, strm.in1_done};
  assign last_tile   = empty_q | (tile_idx_q == n_tiles_q - TILE_W'(1));

  // The launch decision is taken on the edge that enters ISSUE, so the pulse
  // lands in the first ISSUE cycle without any input-to-output path.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      in1_addr_q   <= '0;
      in2_addr_q   <= '0;
      out_addr_q   <= '0;
      in1_stride_q <= '0;
      in2_stride_q <= '0;
      out_stride_q <= '0;
      len_q        <= '0;
      n_tiles_q    <= '0;
      tile_idx_q   <= '0;
      req_q        <= 1'b0;
      empty_q      <= 1'b0;
      done_seen_q  <= '0;
    end else if (clear_i) begin
      state_q      <= S_IDLE;
      in1_addr_q   <= '0;
      in2_addr_q   <= '0;
      out_addr_q   <= '0;
      in1_stride_q <= '0;
      in2_stride_q <= '0;
      out_stride_q <= '0;
      len_q        <= '0;
      n_tiles_q    <= '0;
      tile_idx_q   <= '0;
      req_q        <= 1'b0;
      empty_q      <= 1'b0;
      done_seen_q  <= '0;
    end else begin
      req_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            in1_addr_q   <= in1_base_i;
            in2_addr_q   <= in2_base_i;
            out_addr_q   <= out_base_i;
            in1_stride_q <= in1_stride_i;
            in2_stride_q <= in2_stride_i;
            out_stride_q <= out_stride_i;
            len_q        <= len_i;
            n_tiles_q    <= n_tiles_i;
            tile_idx_q   <= '0;
            // An empty job passes through NEXT so done_o keeps the same
            // two-cycle distance from its trigger as a tile end does.
            if (n_tiles_i == '0 || len_i == '0) begin
              empty_q <= 1'b1;
              state_q <= S_NEXT;
            end else begin
              req_q       <= all_ready;
              done_seen_q <= '0;
              state_q     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (req_q) begin
            state_q <= S_WAIT;
          end else if (all_ready) begin
            req_q       <= 1'b1;
            done_seen_q <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          done_seen_q <= done_seen_d;
          if (&done_seen_d) state_q <= S_NEXT;
        end
        S_NEXT: begin
          if (last_tile) begin
            state_q <= S_DONE;
          end else begin
            tile_idx_q  <= tile_idx_q + TILE_W'(1);
            in1_addr_q  <= in1_addr_q + in1_stride_q;
            in2_addr_q  <= in2_addr_q + in2_stride_q;
            out_addr_q  <= out_addr_q + out_stride_q;
            req_q       <= all_ready;
            done_seen_q <= '0;
            state_q     <= S_ISSUE;
          end
        end
        S_DONE: begin
          empty_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign strm.in1_req      = req_q;
  assign strm.in2_req      = req_q;
  assign strm.out_req      = req_q;
  assign strm.engine_start = req_q;
  assign strm.in1_addr     = in1_addr_q;
  assign strm.in2_addr     = in2_addr_q;
  assign strm.out_addr     = out_addr_q;
  assign strm.len          = len_q;
  assign tile_idx_o        = tile_idx_q;
  assign busy_o            = (state_q != S_IDLE);
  assign done_o            = (state_q == S_DONE);

endmodule

// File: tb/tb_mmult_opt_mdc_tile_sequencer.sv
// Bench for the tile sequencer: streamer model answers each launch with done
// pulses after programmable delays; a launch scoreboard checks every tile.
module tb_mmult_opt_mdc_tile_sequencer;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 16;
  localparam int unsigned TW = 8;

  typedef struct packed {
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [AW-1:0] ao;
    logic [LW-1:0] l;
    logic [TW-1:0] t;
  } launch_t;

  logic          clk = 1'b0, rst_n = 1'b0, clear = 1'b0, start = 1'b0;
  logic [AW-1:0] b1 = '0, b2 = '0, bo = '0, s1 = '0, s2 = '0, so = '0;
  logic [LW-1:0] len = '0;
  logic [TW-1:0] ntl = '0;
  logic [TW-1:0] tile_idx;
  logic          busy, done;

  mmult_opt_mdc_tile_sequencer_if #(.ADDR_W(AW), .LEN_W(LW)) strm ();

  mmult_opt_mdc_tile_sequencer #(.ADDR_W(AW), .LEN_W(LW), .TILE_W(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
    .in1_base_i(b1), .in2_base_i(b2), .out_base_i(bo),
    .in1_stride_i(s1), .in2_stride_i(s2), .out_stride_i(so),
    .len_i(len), .n_tiles_i(ntl), .strm(strm),
    .tile_idx_o(tile_idx), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  launch_t exp_q[$];
  int d1 = 1, d2 = 1, d3 = 1;
  bit kill = 1'b0, stray = 1'b0;
  int last_dn = 0, first_req_cyc = -1, done_cyc = 0;
  int req_cnt = 0, done_total = 0, busy_cnt = 0, done_pending = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [AW-1:0] a1, a2, ao, t1, t2, to,
                           input logic [LW-1:0] l, input logic [TW-1:0] n,
                           output int t0);
    b1 = a1; b2 = a2; bo = ao; s1 = t1; s2 = t2; so = to; len = l; ntl = n;
    if (l != '0) begin
      for (int i = 0; i < int'(n); i++) begin
        launch_t e;
        e.a1 = a1 + t1 * AW'(i);
        e.a2 = a2 + t2 * AW'(i);
        e.ao = ao + to * AW'(i);
        e.l  = l;
        e.t  = TW'(i);
        exp_q.push_back(e);
      end
    end
    done_pending = 1;
    first_req_cyc = -1;
    start = 1'b1;
    t0 = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output int tend);
    int k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk("idle_in_time", k < maxc, 1);
    tend = cyc;
    chk("all_launched", exp_q.size(), 0);
  endtask

  task automatic wait_reqs(input int target, input int maxc);
    int k = 0;
    while (req_cnt < target && k < maxc) begin
      tick(1);
      k++;
    end
    chk("reach_tile2", req_cnt, target);
  endtask

  // streamer model: done pulses d1/d2/d3 cycles after the observed launch
  initial begin : responder
    int c1, c2, c3;
    c1 = 0; c2 = 0; c3 = 0;
    strm.in1_done = 1'b0; strm.in2_done = 1'b0; strm.out_done = 1'b0;
    forever begin
      @(negedge clk);
      if (strm.in1_req === 1'b1) begin c1 = d1; c2 = d2; c3 = d3; end
      @(posedge clk);
      #2;
      strm.in1_done = stray; strm.in2_done = 1'b0; strm.out_done = 1'b0;
      if (kill) begin
        c1 = 0; c2 = 0; c3 = 0;
      end else begin
        if (c1 > 0) begin c1--; if (c1 == 0) begin strm.in1_done = 1'b1; last_dn = cyc; end end
        if (c2 > 0) begin c2--; if (c2 == 0) begin strm.in2_done = 1'b1; last_dn = cyc; end end
        if (c3 > 0) begin c3--; if (c3 == 0) begin strm.out_done = 1'b1; last_dn = cyc; end end
      end
    end
  end

  initial begin : monitor
    launch_t e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if ((strm.in1_req | strm.in2_req | strm.out_req | strm.engine_start) === 1'b1) begin
        req_cnt++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
        chk("req_together", {strm.in1_req, strm.in2_req, strm.out_req, strm.engine_start}, 4'hF);
        chk("launch_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("in1_addr", strm.in1_addr, e.a1);
          chk("in2_addr", strm.in2_addr, e.a2);
          chk("out_addr", strm.out_addr, e.ao);
          chk("len", strm.len, e.l);
          chk("tile_idx", tile_idx, e.t);
          if (e.t != '0) chk("tile_gap", cyc, last_dn + 2);
        end
      end
      if (done === 1'b1) begin
        done_total++;
        done_cyc = cyc;
        chk("done_expected", done_pending, 1);
        if (done_pending > 0) done_pending--;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int t0, tend, d0, r0, bc0, r;
    strm.in1_ready = 1'b1; strm.in2_ready = 1'b1; strm.out_ready = 1'b1;
    tick(3);
    @(negedge clk);
    chk("rst_ctrl", {busy, done, strm.in1_req, strm.in2_req, strm.out_req, strm.engine_start}, 0);
    chk("rst_addr", strm.in1_addr | strm.in2_addr | strm.out_addr, 0);
    chk("rst_len_tile", {strm.len, tile_idx}, 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    stray = 1'b1; tick(1); stray = 1'b0; tick(2);
    chk("stray_idle", busy, 0);

    // single tile
    d1 = 5; d2 = 7; d3 = 10; d0 = done_total; r0 = req_cnt;
    start_job(32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h100, 32'h40, 16'd64, 8'd1, t0);
    @(negedge clk);
    chk("start_busy", busy, 1);
    wait_idle(200, tend);
    chk("first_req_lat", first_req_cyc, t0 + 1);
    chk("single_done_cyc", done_cyc, t0 + 1 + 10 + 2);
    chk("busy_drop", tend, done_cyc + 1);
    chk("single_req_cnt", req_cnt - r0, 1);
    chk("single_done_cnt", done_total - d0, 1);
    tick(1);

    // four tiles, simultaneous dones, ignored restart and config change
    d1 = 2; d2 = 2; d3 = 2; d0 = done_total;
    start_job(32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h100, 32'h40, 16'd64, 8'd4, t0);
    tick(6);
    b1 = 32'hDEAD_0000; ntl = 8'd9; start = 1'b1; tick(1); start = 1'b0;
    wait_idle(400, tend);
    chk("multi_done_cnt", done_total - d0, 1);
    tick(1);

    // reversed done order
    d1 = 3; d2 = 2; d3 = 1; d0 = done_total;
    start_job(32'h4000, 32'h5000, 32'h6000, 32'h20, 32'h10, 32'h8, 16'd16, 8'd3, t0);
    wait_idle(400, tend);
    chk("rev_done_cnt", done_total - d0, 1);
    tick(1);

    // ready stall on in2
    d1 = 2; d2 = 2; d3 = 2; r0 = req_cnt;
    strm.in2_ready = 1'b0;
    start_job(32'h100, 32'h200, 32'h300, 32'h0, 32'h0, 32'h0, 16'd4, 8'd1, t0);
    tick(10);
    chk("stall_noreq", req_cnt - r0, 0);
    chk("stall_busy", busy, 1);
    strm.in2_ready = 1'b1;
    r = cyc;
    wait_idle(200, tend);
    chk("stall_req_cyc", first_req_cyc, r + 1);
    tick(1);

    // minimum job
    d1 = 1; d2 = 1; d3 = 1; bc0 = busy_cnt;
    start_job(32'h10, 32'h20, 32'h30, 32'h0, 32'h0, 32'h0, 16'd1, 8'd1, t0);
    wait_idle(100, tend);
    chk("min_busy", busy_cnt - bc0, 4);
    tick(1);

    // degenerate configurations
    r0 = req_cnt;
    start_job(32'h10, 32'h20, 32'h30, 32'h4, 32'h4, 32'h4, 16'd8, 8'd0, t0);
    wait_idle(50, tend);
    chk("deg_ntiles_done", done_cyc, t0 + 2);
    chk("deg_ntiles_noreq", req_cnt - r0, 0);
    tick(1);
    start_job(32'h10, 32'h20, 32'h30, 32'h4, 32'h4, 32'h4, 16'd0, 8'd3, t0);
    wait_idle(50, tend);
    chk("deg_len_done", done_cyc, t0 + 2);
    chk("deg_len_noreq", req_cnt - r0, 0);
    tick(1);

    // clear_i in WAIT of the second tile
    d1 = 20; d2 = 20; d3 = 20; r0 = req_cnt;
    start_job(32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h100, 32'h40, 16'd64, 8'd4, t0);
    wait_reqs(r0 + 2, 200);
    tick(2);
    chk("clr_pre_tile", tile_idx, 1);
    kill = 1'b1; done_pending = 0; exp_q.delete(); d0 = done_total;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    @(negedge clk);
    chk("clr_busy", busy, 0);
    chk("clr_tile", tile_idx, 0);
    chk("clr_addr", strm.in1_addr | strm.in2_addr | strm.out_addr, 0);
    chk("clr_len", strm.len, 0);
    tick(5);
    chk("clr_no_done", done_total - d0, 0);
    kill = 1'b0;

    // async reset in WAIT of the second tile
    r0 = req_cnt;
    start_job(32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h100, 32'h40, 16'd64, 8'd4, t0);
    wait_reqs(r0 + 2, 200);
    tick(2);
    kill = 1'b1; done_pending = 0; exp_q.delete(); d0 = done_total;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ctrl", {busy, done, strm.in1_req, tile_idx}, 0);
    chk("arst_addr", strm.in1_addr | strm.in2_addr | strm.out_addr, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("arst_no_done", done_total - d0, 0);
    kill = 1'b0;

    // fresh job after the aborts
    d1 = 2; d2 = 3; d3 = 4; d0 = done_total;
    start_job(32'h7000, 32'h8000, 32'h9000, 32'h80, 32'h80, 32'h80, 16'd32, 8'd2, t0);
    wait_idle(200, tend);
    chk("fresh_done_cnt", done_total - d0, 1);
    tick(1);

    // address wrap
    d1 = 1; d2 = 2; d3 = 1; d0 = done_total;
    start_job(32'hFFFF_FF00, 32'h0000_1000, 32'hFFFF_FFC0, 32'h100, 32'h4, 32'h40, 16'd2, 8'd2, t0);
    wait_idle(200, tend);
    chk("wrap_done_cnt", done_total - d0, 1);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
